// File: rtl/note_length_counter_pkg.sv
// Shared definitions for the note-duration timer: channel state encoding and
// the lane-offset helper used to pack/unpack the flattened per-channel buses.
package note_length_counter_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } ch_state_e;

  // Bit offset of channel `ch` inside a bus of `width`-bit lanes.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/length_counter_ch.sv
// Single note-length channel: loads a duration, counts it down on the shared
// tick, and raises a registered one-cycle done pulse at expiry.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_STOPPED | idle; ticks, halt and loop ignored; waits for a load
//   ST_RUNNING | counting down on non-halted ticks; expires on tick at count 0
module length_counter_ch
  import note_length_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_duration,
  input  logic             i_loop,
  input  logic             i_halt,
  input  logic             i_stop,
  output logic             o_active,
  output logic             o_done,
  output logic [WIDTH-1:0] o_remaining
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // State, count, reload value and done pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_STOPPED;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next state: stop beats load, load beats tick. Expiry happens on the tick
  // that finds the count already at zero, so a duration D takes D+1 ticks and
  // the count never wraps.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (i_stop) begin
      state_d = ST_STOPPED;
      count_d = '0;
    end else if (i_load) begin
      state_d  = ST_RUNNING;
      count_d  = i_duration;
      reload_d = i_duration;
    end else if (i_tick && !i_halt && (state_q == ST_RUNNING)) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        done_d = 1'b1;
        if (i_loop) begin
          count_d = reload_q;
        end else begin
          state_d = ST_STOPPED;
        end
      end
    end
  end

  assign o_active    = (state_q == ST_RUNNING);
  assign o_done      = done_q;
  assign o_remaining = count_q;

endmodule

// File: rtl/note_length_counter.sv
// Multi-channel note-duration timer. Each channel is an independent
// length_counter_ch; only the tick strobe is shared. Duration and remaining
// count buses are packed with channel c at bits [c*WIDTH +: WIDTH].
module note_length_counter
  import note_length_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH*WIDTH-1:0] i_duration,
  input  logic [NUM_CH-1:0]       i_loop,
  input  logic [NUM_CH-1:0]       i_halt,
  input  logic [NUM_CH-1:0]       i_stop,
  output logic [NUM_CH-1:0]       o_active,
  output logic [NUM_CH-1:0]       o_done,
  output logic [NUM_CH*WIDTH-1:0] o_remaining
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    length_counter_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_tick     (i_tick),
      .i_load     (i_load[c]),
      .i_duration (i_duration[ch_lsb(c, WIDTH) +: WIDTH]),
      .i_loop     (i_loop[c]),
      .i_halt     (i_halt[c]),
      .i_stop     (i_stop[c]),
      .o_active   (o_active[c]),
      .o_done     (o_done[c]),
      .o_remaining(o_remaining[ch_lsb(c, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_note_length_counter.sv
// Directed bench for note_length_counter (4 channels, 8-bit counts).
module tb_note_length_counter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_tick;
  logic [3:0]  i_load;
  logic [31:0] i_duration;
  logic [3:0]  i_loop;
  logic [3:0]  i_halt;
  logic [3:0]  i_stop;
  logic [3:0]  o_active;
  logic [3:0]  o_done;
  logic [31:0] o_remaining;

  int total = 0;
  int bad   = 0;

  note_length_counter #(.NUM_CH(4), .WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_load     (i_load),
    .i_duration (i_duration),
    .i_loop     (i_loop),
    .i_halt     (i_halt),
    .i_stop     (i_stop),
    .o_active   (o_active),
    .o_done     (o_done),
    .o_remaining(o_remaining)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs set afterwards land on the following edge
  // and outputs read afterwards are stable post-edge values.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic tick1();
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
  endtask

  task automatic load(input logic [3:0] mask);
    i_load = mask;
    cyc(1);
    i_load = '0;
  endtask

  function automatic logic [7:0] rem(input int c);
    return o_remaining[c*8 +: 8];
  endfunction

  logic [7:0] exp_rem;
  logic       seen;

  initial begin
    i_rst = 1'b1; i_tick = 0; i_load = 0; i_duration = 0;
    i_loop = 0; i_halt = 0; i_stop = 0;
    cyc(2);
    i_rst = 1'b0;
    check("rst_active", 32'(o_active), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_remaining", o_remaining, 0);

    // ch0 one-shot D=3
    i_duration[7:0] = 8'd3;
    load(4'b0001);
    check("c0_load_active", 32'(o_active[0]), 1);
    check("c0_load_rem", 32'(rem(0)), 3);
    for (int k = 1; k <= 4; k++) begin
      tick1();
      exp_rem = (k < 3) ? 8'(3 - k) : 8'd0;
      check($sformatf("c0_rem_t%0d", k), 32'(rem(0)), 32'(exp_rem));
      check($sformatf("c0_done_t%0d", k), 32'(o_done[0]), (k == 4) ? 1 : 0);
      check($sformatf("c0_active_t%0d", k), 32'(o_active[0]), (k < 4) ? 1 : 0);
      cyc(2);
      check($sformatf("c0_done_gap%0d", k), 32'(o_done[0]), 0);
    end

    // ch1 loop D=0: done on every tick
    i_duration[15:8] = 8'd0;
    i_loop[1] = 1'b1;
    load(4'b0010);
    for (int k = 1; k <= 5; k++) begin
      tick1();
      check($sformatf("c1_done_t%0d", k), 32'(o_done[1]), 1);
      check($sformatf("c1_active_t%0d", k), 32'(o_active[1]), 1);
      check($sformatf("c1_rem_t%0d", k), 32'(rem(1)), 0);
      cyc(1);
      check($sformatf("c1_done_gap%0d", k), 32'(o_done[1]), 0);
    end
    i_stop[1] = 1'b1;
    cyc(1);
    i_stop[1] = 1'b0;
    check("c1_stop_active", 32'(o_active[1]), 0);
    check("c1_stop_done", 32'(o_done[1]), 0);
    tick1();
    check("c1_after_stop_done", 32'(o_done[1]), 0);
    i_loop[1] = 1'b0;

    // ch2 halt
    i_duration[23:16] = 8'd5;
    load(4'b0100);
    tick1();
    tick1();
    check("c2_pre_halt_rem", 32'(rem(2)), 3);
    i_halt[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick1();
      check($sformatf("c2_halt_rem%0d", k), 32'(rem(2)), 3);
      check($sformatf("c2_halt_done%0d", k), 32'(o_done[2]), 0);
    end
    i_halt[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick1();
      check($sformatf("c2_done_t%0d", k), 32'(o_done[2]), (k == 4) ? 1 : 0);
    end
    check("c2_end_active", 32'(o_active[2]), 0);

    // ch3 retrigger together with a tick
    i_duration[31:24] = 8'd4;
    load(4'b1000);
    tick1();
    tick1();
    check("c3_pre_retrig_rem", 32'(rem(3)), 2);
    i_duration[31:24] = 8'd6;
    i_load = 4'b1000;
    tick1();
    i_load = '0;
    check("c3_retrig_rem", 32'(rem(3)), 6);
    check("c3_retrig_done", 32'(o_done[3]), 0);
    check("c3_retrig_active", 32'(o_active[3]), 1);
    for (int k = 1; k <= 7; k++) begin
      tick1();
      check($sformatf("c3_done_t%0d", k), 32'(o_done[3]), (k == 7) ? 1 : 0);
    end
    check("c3_end_active", 32'(o_active[3]), 0);

    // simultaneous expiry and independence
    i_duration[7:0] = 8'd1;
    i_duration[15:8] = 8'd1;
    i_duration[23:16] = 8'd200;
    load(4'b0111);
    tick1();
    check("sim_t1_done", 32'(o_done), 0);
    check("sim_t1_rem2", 32'(rem(2)), 199);
    tick1();
    check("sim_t2_done", 32'(o_done), 32'h3);
    check("sim_t2_rem2", 32'(rem(2)), 198);
    check("sim_t2_active", 32'(o_active), 32'h4);

    // reset with everything running
    i_duration = {8'd10, 8'd10, 8'd10, 8'd10};
    load(4'b1111);
    tick1();
    check("pre_rst_active", 32'(o_active), 32'hF);
    i_rst = 1'b1;
    cyc(1);
    i_rst = 1'b0;
    check("mid_rst_active", 32'(o_active), 0);
    check("mid_rst_done", 32'(o_done), 0);
    check("mid_rst_rem", o_remaining, 0);

    // reset on the expiry tick suppresses done
    i_duration[7:0] = 8'd0;
    load(4'b0001);
    i_rst = 1'b1;
    tick1();
    i_rst = 1'b0;
    check("rst_expiry_done", 32'(o_done), 0);
    check("rst_expiry_active", 32'(o_active), 0);

    // max duration: 256 ticks
    i_duration[7:0] = 8'd255;
    load(4'b0001);
    seen = 1'b0;
    i_tick = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      cyc(1);
      seen = seen | o_done[0];
    end
    check("max_early_done", 32'(seen), 0);
    check("max_rem_255", 32'(rem(0)), 0);
    check("max_active_255", 32'(o_active[0]), 1);
    cyc(1);
    i_tick = 1'b0;
    check("max_done_256", 32'(o_done[0]), 1);
    check("max_active_256", 32'(o_active[0]), 0);

    // stop together with load
    i_duration[15:8] = 8'd9;
    i_stop[1] = 1'b1;
    load(4'b0010);
    i_stop[1] = 1'b0;
    check("stop_load_active", 32'(o_active[1]), 0);
    check("stop_load_rem", 32'(rem(1)), 0);
    tick1();
    check("stop_load_done", 32'(o_done[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
